raster_pattern_gen: RTL and testbench

- Parametrised colour test-pattern generator for the display path.
- Sweeps a WIDTH x HEIGHT raster, X fastest, and emits one pixel (X, Y, R, G, B) per accepted transfer.
- Output uses a valid/ready handshake so a framebuffer writer or VGA FIFO can back-pressure it.
- Steps through eight fixed patterns, either automatically after DWELL frames or from a manual select, always switching on frame boundaries.

---
 rtl/raster_pattern_gen.sv | 127 ++++++++++++
 tb/tb_raster_pattern_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/raster_pattern_gen.sv
// Raster colour test-pattern generator with valid/ready output; eight patterns, auto or manual select.
// Optional feature: define PATGEN_BORDER_EN to draw a one-pixel frame border over every pattern.
module raster_pattern_gen #(
  parameter int XW    = 8,
  parameter int YW    = 8,
  parameter int CW    = 3,
  parameter int DWELL = 16
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          EN,
  input  logic          AUTO,
  input  logic [2:0]    PAT_SEL,
  input  logic          READY,
  output logic          VALID,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic [CW-1:0] R,
  output logic [CW-1:0] G,
  output logic [CW-1:0] B,
  output logic          SOF,
  output logic          EOL,
  output logic          EOF,
  output logic [2:0]    PAT
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam int FW = $clog2(DWELL + 1);

  logic [0:0]    state;
  logic [XW-1:0] xq;
  logic [YW-1:0] yq;
  logic [2:0]    pat;
  logic [FW-1:0] fcnt;
  logic          auto_q;   // AUTO as sampled at the previous frame boundary

  logic x_end, y_end;
  assign x_end = &xq;
  assign y_end = &yq;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state  <= S_IDLE;
      xq     <= '0;
      yq     <= '0;
      pat    <= '0;
      fcnt   <= '0;
      auto_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (EN) begin
            state  <= S_RUN;
            xq     <= '0;
            yq     <= '0;
            auto_q <= AUTO;
            if (!AUTO || !auto_q) fcnt <= '0;
            if (!AUTO) pat <= PAT_SEL;
          end
        end
        default: begin
          if (READY) begin
            xq <= xq + XW'(1);
            if (x_end) yq <= yq + YW'(1);
            if (x_end && y_end) begin
              auto_q <= AUTO;
              // a 0->1 AUTO switch restarts the dwell count without advancing
              if (AUTO && auto_q) begin
                if (fcnt == FW'(DWELL - 1)) begin
                  fcnt <= '0;
                  pat  <= pat + 3'd1;
                end else begin
                  fcnt <= fcnt + FW'(1);
                end
              end else begin
                fcnt <= '0;
                if (!AUTO && EN) pat <= PAT_SEL;
              end
              if (!EN) state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // colour derives from the same registers presented on X/Y/PAT
  logic [CW-1:0] xm, ym, r, g, b;
  assign xm = xq[XW-1 -: CW];
  assign ym = yq[YW-1 -: CW];

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (pat)
      3'd0: begin r = '1; g = '1; b = '1; end
      3'd1: begin g = '1; b = '1; end
      3'd2: r = '1;
      3'd3: begin r = '1; b = '1; end
      3'd4: g = '1;
      3'd5: begin r = '1; g = '1; end
      3'd6: begin g = ym; b = xm; end
      default: begin r = xm; g = ym; end
    endcase
`ifdef PATGEN_BORDER_EN
    if (xq == '0 || x_end || yq == '0 || y_end) begin
      r = (pat == 3'd0) ? '0 : '1;
      g = r;
      b = r;
    end
`endif
  end

  assign VALID = (state == S_RUN);
  assign X     = xq;
  assign Y     = yq;
  assign PAT   = pat;
  assign R     = VALID ? r : '0;
  assign G     = VALID ? g : '0;
  assign B     = VALID ? b : '0;
  assign SOF   = VALID && (xq == '0) && (yq == '0);
  assign EOL   = VALID && x_end;
  assign EOF   = VALID && x_end && y_end;

endmodule

// File: tb/tb_raster_pattern_gen.sv
// Randomized bench for raster_pattern_gen against a pixel-index/frame-level reference model.
module tb_raster_pattern_gen;
  localparam int XW = 4, YW = 4, CW = 3, DWELL = 2;
  localparam int W = 1 << XW, H = 1 << YW, N = W * H, A = (1 << CW) - 1;

  logic CLK = 1'b0, NRST = 1'b0, EN = 1'b0, AUTO = 1'b0, READY = 1'b0;
  logic [2:0] PAT_SEL = 3'd0;
  logic VALID, SOF, EOL, EOF;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic [CW-1:0] R, G, B;
  logic [2:0] PAT;

  raster_pattern_gen #(.XW(XW), .YW(YW), .CW(CW), .DWELL(DWELL)) dut (
    .CLK(CLK), .NRST(NRST), .EN(EN), .AUTO(AUTO), .PAT_SEL(PAT_SEL), .READY(READY),
    .VALID(VALID), .X(X), .Y(Y), .R(R), .G(G), .B(B),
    .SOF(SOF), .EOL(EOL), .EOF(EOF), .PAT(PAT)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3*CW-1:0] ref_rgb(input int p, input int x, input int y);
    int xm, ym, r, g, b;
    xm = x >> (XW - CW);
    ym = y >> (YW - CW);
    r = 0; g = 0; b = 0;
    case (p)
      0: begin r = A; g = A; b = A; end
      1: begin g = A; b = A; end
      2: r = A;
      3: begin r = A; b = A; end
      4: g = A;
      5: begin r = A; g = A; end
      6: begin g = ym; b = xm; end
      default: begin r = xm; g = ym; end
    endcase
`ifdef PATGEN_BORDER_EN
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) begin
      r = (p == 0) ? 0 : A; g = r; b = r;
    end
`endif
    return {r[CW-1:0], g[CW-1:0], b[CW-1:0]};
  endfunction

  // reference: is a frame in flight, which pixel index, which pattern, frames shown so far
  bit m_valid = 0, m_prev_auto = 0, was_rst = 0;
  int m_idx = 0, m_pat = 0, m_frames = 0;
  int acc_cnt = 0;

  task automatic model_step();
    if (!NRST) begin
      m_valid = 0; m_idx = 0; m_pat = 0; m_frames = 0; m_prev_auto = 0;
    end else if (!m_valid) begin
      if (EN) begin
        m_valid = 1; m_idx = 0;
        if (!AUTO || !m_prev_auto) m_frames = 0;
        m_prev_auto = AUTO;
        if (!AUTO) m_pat = PAT_SEL;
      end
    end else if (READY) begin
      if (m_idx == N - 1) begin
        m_idx = 0;
        if (AUTO && m_prev_auto) begin
          m_frames++;
          if (m_frames == DWELL) begin m_frames = 0; m_pat = (m_pat + 1) % 8; end
        end else begin
          m_frames = 0;
          if (!AUTO && EN) m_pat = PAT_SEL;
        end
        m_prev_auto = AUTO;
        m_valid = EN;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic compare();
    int ex, ey;
    chk("valid", VALID, m_valid);
    chk("pat", PAT, m_pat);
    if (was_rst) begin
      chk("rst_xy", {X, Y}, 0);
      chk("rst_rgb", {R, G, B}, 0);
      chk("rst_flags", {SOF, EOL, EOF}, 0);
    end
    if (m_valid) begin
      ex = m_idx % W;
      ey = m_idx / W;
      chk("x", X, ex);
      chk("y", Y, ey);
      chk("rgb", {R, G, B}, ref_rgb(m_pat, ex, ey));
      chk("sof", SOF, m_idx == 0);
      chk("eol", EOL, ex == W - 1);
      chk("eof", EOF, m_idx == N - 1);
    end else begin
      chk("idle_flags", {SOF, EOL, EOF}, 0);
    end
  endtask

  task automatic cycle();
    bit acc, sof_p, eof_p;
    acc = NRST && VALID && READY;
    sof_p = SOF;
    eof_p = EOF;
    @(posedge CLK);
    model_step();
    was_rst = !NRST;
    if (!NRST) acc_cnt = 0;
    else if (acc) begin
      acc_cnt = sof_p ? 1 : acc_cnt + 1;
      if (eof_p) chk("frame_len", acc_cnt, N);
    end
    #1 compare();
  endtask

  initial begin
    repeat (2) cycle();
    NRST = 1'b1; EN = 1'b1; AUTO = 1'b0; PAT_SEL = 3'd2; READY = 1'b1;
    repeat (N + 4) cycle();
    // back-pressured manual frames with mid-frame select changes
    for (int i = 0; i < 3000; i++) begin
      READY = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) PAT_SEL = 3'($urandom_range(0, 7));
      cycle();
    end
    // auto advance long enough to wrap all eight patterns
    AUTO = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      READY = ($urandom_range(0, 3) != 0);
      PAT_SEL = 3'($urandom_range(0, 7));
      cycle();
    end
    // everything random, including EN drops, AUTO flips and mid-frame resets
    for (int i = 0; i < 12000; i++) begin
      READY = $urandom_range(0, 1);
      if ($urandom_range(0, 199) == 0) EN = ~EN;
      if ($urandom_range(0, 999) == 0) AUTO = ~AUTO;
      if ($urandom_range(0, 29) == 0) PAT_SEL = 3'($urandom_range(0, 7));
      NRST = ($urandom_range(0, 2999) != 0);
      cycle();
    end
    NRST = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
